mips_cpu_bus_arbiter: RTL and testbench

Two-port arbiter sharing the CPU's single Avalon-style memory master port (read/write/byteenable/waitrequest, readdata one cycle after acceptance) between the instruction-fetch port (port 0, read-only) and the load/store port (port 1, read/write). It sits between the CPU core and the bus memory, serialises accesses with round-robin priority, honours waitrequest, and returns one ack per accepted request.

---
 rtl/mips_cpu_bus_pkg.sv | 14 +
 rtl/mips_cpu_bus_arbiter_if.sv | 23 ++
 rtl/mips_cpu_bus_rr_pick.sv | 19 +
 rtl/mips_cpu_bus_arbiter.sv | 133 +++++++++++++
 tb/tb_mips_cpu_bus_arbiter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_cpu_bus_pkg.sv
// Shared types and constants for the CPU memory-bus arbiter.
package mips_cpu_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic       PORT_I  = 1'b0;
    localparam logic       PORT_D  = 1'b1;
    localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/mips_cpu_bus_arbiter_if.sv
// Avalon-style memory master bus shared by both CPU ports.
interface mips_cpu_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   writedata;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;

    modport master (
        output address, read, write, byteenable, writedata,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, byteenable, writedata,
        output waitrequest, readdata
    );
endinterface

// File: rtl/mips_cpu_bus_rr_pick.sv
// Two-way round-robin chooser: on a tie the port not granted last time wins.
module mips_cpu_bus_rr_pick
    import mips_cpu_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       valid,
    output logic       winner
);
    // NOTE: every output gets a default before any branch so no latch is inferred.
    always_comb begin
        valid  = |req;
        winner = PORT_I;
        if (req == 2'b11)
            winner = ~last_grant;
        else if (req[1])
            winner = PORT_D;
    end
endmodule

// File: rtl/mips_cpu_bus_arbiter.sv
// Serialises instruction-fetch and load/store requests onto one memory bus,
// one outstanding transaction at a time, with a one-cycle ack per request.
module mips_cpu_bus_arbiter
    import mips_cpu_bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_ack,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W/8-1:0] d_byteenable,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                err,
    mips_cpu_bus_arbiter_if.master bus
);
    state_t              state_q, state_d;
    logic                last_grant_q, err_q, gnt_q, we_q;
    logic                pick_valid, pick_winner;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W/8-1:0] win_be;
    logic [DATA_W-1:0]   win_wdata;
    logic                win_we, win_aligned, accepted;
    logic [DATA_W-1:0]   resp_data;

    mips_cpu_bus_rr_pick u_pick (
        .req        ({d_req, i_req}),
        .last_grant (last_grant_q),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    assign accepted = (bus.read | bus.write) & ~bus.waitrequest;

    // Fetch port is a full-word read only.
    always_comb begin
        win_addr  = i_addr;
        win_be    = BE_WORD;
        win_wdata = '0;
        win_we    = 1'b0;
        if (pick_winner == PORT_D) begin
            win_addr  = d_addr;
            win_be    = d_byteenable;
            win_wdata = d_wdata;
            win_we    = d_we;
        end
        win_aligned = (win_addr[1:0] == 2'b00);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_valid) state_d = win_aligned ? BUS : RESP;
            BUS:     if (accepted) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q   <= PORT_D;
            err_q          <= 1'b0;
            gnt_q          <= PORT_I;
            we_q           <= 1'b0;
            bus.address    <= '0;
            bus.read       <= 1'b0;
            bus.write      <= 1'b0;
            bus.byteenable <= '0;
            bus.writedata  <= '0;
        end else begin
            case (state_q)
                IDLE: if (pick_valid) begin
                    gnt_q <= pick_winner;
                    we_q  <= win_we;
                    // A misaligned winner never touches the bus; it is answered with err.
                    if (win_aligned) begin
                        bus.address    <= win_addr;
                        bus.byteenable <= win_be;
                        bus.writedata  <= win_wdata;
                        bus.read       <= ~win_we;
                        bus.write      <= win_we;
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                BUS: if (accepted) begin
                    bus.read  <= 1'b0;
                    bus.write <= 1'b0;
                end
                RESP: begin
                    last_grant_q <= gnt_q;
                    err_q        <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        resp_data = (we_q || err_q) ? '0 : bus.readdata;
        i_ack     = 1'b0;
        d_ack     = 1'b0;
        i_rdata   = '0;
        d_rdata   = '0;
        err       = 1'b0;
        if (state_q == RESP) begin
            err = err_q;
            if (gnt_q == PORT_D) begin
                d_ack   = 1'b1;
                d_rdata = resp_data;
            end else begin
                i_ack   = 1'b1;
                i_rdata = resp_data;
            end
        end
    end
endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// Directed bench for mips_cpu_bus_arbiter: cycle table plus write/wait and reset sequences.
module tb_mips_cpu_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_byteenable;
    logic        i_ack, d_ack, err;
    logic [31:0] i_rdata, d_rdata;
    int          total = 0;
    int          bad   = 0;

    mips_cpu_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mips_cpu_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .reset        (rst),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_ack        (i_ack),
        .i_rdata      (i_rdata),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_byteenable (d_byteenable),
        .d_wdata      (d_wdata),
        .d_ack        (d_ack),
        .d_rdata      (d_rdata),
        .err          (err),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    // Memory model: registered readdata one cycle after read acceptance.
    logic [31:0] mem [0:63];

    function automatic logic [31:0] init_word(input int idx);
        case (idx)
            4:       return 32'hDEADBEEF;
            5:       return 32'hA5A50005;
            6:       return 32'h66660006;
            9:       return 32'h99990009;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            bus.readdata <= 32'h0;
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
        end else begin
            if (bus.read && !bus.waitrequest)
                bus.readdata <= mem[bus.address[7:2]];
            if (bus.write && !bus.waitrequest)
                for (int b = 0; b < 4; b++)
                    if (bus.byteenable[b])
                        mem[bus.address[7:2]][8*b +: 8] <= bus.writedata[8*b +: 8];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rw_exclusive", {31'b0, bus.read & bus.write}, 32'h0);
    endtask

    task automatic wait_d_ack(input string name, input logic [31:0] exp);
        int k = 0;
        while (!d_ack && k < 10) begin
            step();
            k++;
        end
        check({name, "_ack"}, {31'b0, d_ack}, 32'h1);
        check({name, "_rdata"}, d_rdata, exp);
        check({name, "_err"}, {31'b0, err}, 32'h0);
        d_req = 1'b0;
        step();
    endtask

    typedef struct {
        logic        rst, i_req;
        logic [31:0] i_addr;
        logic        d_req, d_we;
        logic [31:0] d_addr;
        logic [3:0]  d_be;
        logic        e_read, e_write;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic        e_iack, e_dack, e_err;
        logic [31:0] e_irdata, e_drdata;
    } vec_t;

    function automatic vec_t mk(
        input logic r, input logic ir, input logic [31:0] ia,
        input logic dr, input logic dw, input logic [31:0] da, input logic [3:0] db,
        input logic erd, input logic ewr, input logic [31:0] ea, input logic [3:0] eb,
        input logic eia, input logic eda, input logic ee,
        input logic [31:0] eir, input logic [31:0] edr);
        vec_t v;
        v.rst = r;  v.i_req = ir; v.i_addr = ia;
        v.d_req = dr; v.d_we = dw; v.d_addr = da; v.d_be = db;
        v.e_read = erd; v.e_write = ewr; v.e_addr = ea; v.e_be = eb;
        v.e_iack = eia; v.e_dack = eda; v.e_err = ee;
        v.e_irdata = eir; v.e_drdata = edr;
        return v;
    endfunction

    vec_t vecs [19];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //              rst ir ia     dr dw da     db    | rd wr addr   be    ia da er irdata        drdata
        vecs[0]  = mk(0, 0, 32'h00, 0, 0, 32'h00, 4'h0,  0, 0, 32'h00, 4'h0, 0, 0, 0, 32'h0,        32'h0);
        vecs[1]  = mk(0, 1, 32'h10, 0, 0, 32'h00, 4'h0,  0, 0, 32'h00, 4'h0, 0, 0, 0, 32'h0,        32'h0);
        vecs[2]  = mk(0, 1, 32'h10, 0, 0, 32'h00, 4'h0,  1, 0, 32'h10, 4'hF, 0, 0, 0, 32'h0,        32'h0);
        vecs[3]  = mk(0, 1, 32'h10, 0, 0, 32'h00, 4'h0,  0, 0, 32'h00, 4'h0, 1, 0, 0, 32'hDEADBEEF, 32'h0);
        vecs[4]  = mk(0, 0, 32'h00, 0, 0, 32'h00, 4'h0,  0, 0, 32'h00, 4'h0, 0, 0, 0, 32'h0,        32'h0);
        vecs[5]  = mk(0, 0, 32'h00, 1, 0, 32'h22, 4'hF,  0, 0, 32'h00, 4'h0, 0, 0, 0, 32'h0,        32'h0);
        vecs[6]  = mk(0, 0, 32'h00, 1, 0, 32'h22, 4'hF,  0, 0, 32'h00, 4'h0, 0, 1, 1, 32'h0,        32'h0);
        vecs[7]  = mk(0, 0, 32'h00, 0, 0, 32'h00, 4'h0,  0, 0, 32'h00, 4'h0, 0, 0, 0, 32'h0,        32'h0);
        vecs[8]  = mk(1, 0, 32'h00, 0, 0, 32'h00, 4'h0,  0, 0, 32'h00, 4'h0, 0, 0, 0, 32'h0,        32'h0);
        vecs[9]  = mk(0, 1, 32'h14, 1, 0, 32'h18, 4'hC,  0, 0, 32'h00, 4'h0, 0, 0, 0, 32'h0,        32'h0);
        vecs[10] = mk(0, 1, 32'h14, 1, 0, 32'h18, 4'hC,  1, 0, 32'h14, 4'hF, 0, 0, 0, 32'h0,        32'h0);
        vecs[11] = mk(0, 1, 32'h14, 1, 0, 32'h18, 4'hC,  0, 0, 32'h00, 4'h0, 1, 0, 0, 32'hA5A50005, 32'h0);
        vecs[12] = mk(0, 1, 32'h14, 1, 0, 32'h18, 4'hC,  0, 0, 32'h00, 4'h0, 0, 0, 0, 32'h0,        32'h0);
        vecs[13] = mk(0, 1, 32'h14, 1, 0, 32'h18, 4'hC,  1, 0, 32'h18, 4'hC, 0, 0, 0, 32'h0,        32'h0);
        vecs[14] = mk(0, 1, 32'h14, 1, 0, 32'h18, 4'hC,  0, 0, 32'h00, 4'h0, 0, 1, 0, 32'h0,        32'h66660006);
        vecs[15] = mk(0, 1, 32'h14, 1, 0, 32'h18, 4'hC,  0, 0, 32'h00, 4'h0, 0, 0, 0, 32'h0,        32'h0);
        vecs[16] = mk(0, 1, 32'h14, 1, 0, 32'h18, 4'hC,  1, 0, 32'h14, 4'hF, 0, 0, 0, 32'h0,        32'h0);
        vecs[17] = mk(0, 1, 32'h14, 1, 0, 32'h18, 4'hC,  0, 0, 32'h00, 4'h0, 1, 0, 0, 32'hA5A50005, 32'h0);
        vecs[18] = mk(0, 0, 32'h00, 0, 0, 32'h00, 4'h0,  0, 0, 32'h00, 4'h0, 0, 0, 0, 32'h0,        32'h0);

        rst = 1'b1;
        i_req = 1'b0; i_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_byteenable = 4'h0; d_wdata = 32'h0;
        bus.waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_read",       {31'b0, bus.read},  32'h0);
        check("rst_write",      {31'b0, bus.write}, 32'h0);
        check("rst_address",    bus.address,        32'h0);
        check("rst_byteenable", {28'b0, bus.byteenable}, 32'h0);
        check("rst_writedata",  bus.writedata,      32'h0);
        check("rst_i_ack",      {31'b0, i_ack},     32'h0);
        check("rst_d_ack",      {31'b0, d_ack},     32'h0);
        check("rst_err",        {31'b0, err},       32'h0);
        check("rst_i_rdata",    i_rdata,            32'h0);
        check("rst_d_rdata",    d_rdata,            32'h0);

        for (int n = 0; n < 19; n++) begin
            rst          = vecs[n].rst;
            i_req        = vecs[n].i_req;
            i_addr       = vecs[n].i_addr;
            d_req        = vecs[n].d_req;
            d_we         = vecs[n].d_we;
            d_addr       = vecs[n].d_addr;
            d_byteenable = vecs[n].d_be;
            d_wdata      = 32'h0;
            check($sformatf("r%0d_read", n),    {31'b0, bus.read},  {31'b0, vecs[n].e_read});
            check($sformatf("r%0d_write", n),   {31'b0, bus.write}, {31'b0, vecs[n].e_write});
            check($sformatf("r%0d_i_ack", n),   {31'b0, i_ack},     {31'b0, vecs[n].e_iack});
            check($sformatf("r%0d_d_ack", n),   {31'b0, d_ack},     {31'b0, vecs[n].e_dack});
            check($sformatf("r%0d_err", n),     {31'b0, err},       {31'b0, vecs[n].e_err});
            check($sformatf("r%0d_i_rdata", n), i_rdata,            vecs[n].e_irdata);
            check($sformatf("r%0d_d_rdata", n), d_rdata,            vecs[n].e_drdata);
            if (vecs[n].e_read || vecs[n].e_write) begin
                check($sformatf("r%0d_address", n), bus.address, vecs[n].e_addr);
                check($sformatf("r%0d_be", n), {28'b0, bus.byteenable}, {28'b0, vecs[n].e_be});
            end
            step();
        end

        // Write with three stall cycles, then read it back.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_byteenable = 4'b0011; d_wdata = 32'h12345678;
        bus.waitrequest = 1'b1;
        check("wr_c0_write", {31'b0, bus.write}, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("wr_c%0d_write", k), {31'b0, bus.write}, 32'h1);
            check($sformatf("wr_c%0d_d_ack", k), {31'b0, d_ack}, 32'h0);
            check($sformatf("wr_c%0d_address", k), bus.address, 32'h20);
            check($sformatf("wr_c%0d_wdata", k), bus.writedata, 32'h12345678);
            check($sformatf("wr_c%0d_be", k), {28'b0, bus.byteenable}, 32'h3);
            if (k == 4) bus.waitrequest = 1'b0;
        end
        step();
        check("wr_ack",   {31'b0, d_ack},     32'h1);
        check("wr_write", {31'b0, bus.write}, 32'h0);
        check("wr_rdata", d_rdata,            32'h0);
        check("wr_err",   {31'b0, err},       32'h0);
        d_req = 1'b0; d_we = 1'b0;
        step();
        d_req = 1'b1; d_addr = 32'h20; d_byteenable = 4'hF;
        wait_d_ack("readback", 32'h00005678);

        // Reset in the second stall cycle of a load.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h24; d_byteenable = 4'hF;
        bus.waitrequest = 1'b1;
        step();
        check("rb_c1_read", {31'b0, bus.read}, 32'h1);
        step();
        check("rb_c2_read", {31'b0, bus.read}, 32'h1);
        check("rb_c2_d_ack", {31'b0, d_ack}, 32'h0);
        rst = 1'b1;
        step();
        check("rb_c3_read",    {31'b0, bus.read},  32'h0);
        check("rb_c3_write",   {31'b0, bus.write}, 32'h0);
        check("rb_c3_d_ack",   {31'b0, d_ack},     32'h0);
        check("rb_c3_address", bus.address,        32'h0);
        rst = 1'b0;
        bus.waitrequest = 1'b0;
        wait_d_ack("reissue", 32'h99990009);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
